// File: rtl/pipeline_reg_pkg.sv
// Shared types for the elastic pipeline stage register.
// The stage keeps a main entry plus one skid entry behind it.
package pipeline_reg_pkg;

    typedef enum logic [1:0] {
        Empty = 2'd0,
        Busy  = 2'd1,
        Full  = 2'd2
    } skid_state_t;

    localparam int OccupancyWidth = 2;

endpackage

// File: rtl/pipeline_data_reg.sv
// Payload register with load enable and a clear that reloads the reset value.
// The clear input has priority over the load enable.
module pipeline_data_reg #(
    parameter int                   DataWidth  = 64,
    parameter logic [DataWidth-1:0] ResetValue = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 clear,
    input  logic [DataWidth-1:0] d,
    output logic [DataWidth-1:0] q
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            q <= ResetValue;
        end else if (clear) begin
            q <= ResetValue;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_skid_reg.sv
// Elastic valid/ready pipeline register with a two-entry skid buffer.
// in_ready depends only on registered state, so no combinational ready path crosses the stage.
//
// state | meaning
// Empty | nothing held; out_valid low
// Busy  | main entry holds a payload; skid entry free
// Full  | main and skid both hold payloads; skid is the younger one
module pipeline_skid_reg
    import pipeline_reg_pkg::*;
#(
    parameter int                   DataWidth    = 64,
    parameter logic [DataWidth-1:0] ResetValue   = '0,
    parameter bit                   ClearOnFlush = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DataWidth-1:0]      in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DataWidth-1:0]      out_data,
    output logic [OccupancyWidth-1:0] occupancy
);

    skid_state_t          state_q;
    skid_state_t          state_d;
    logic [DataWidth-1:0] main_q;
    logic [DataWidth-1:0] skid_q;
    logic [DataWidth-1:0] main_d;
    logic                 main_load;
    logic                 main_from_skid;
    logic                 skid_load;
    logic                 payload_clear;
    logic                 accept;
    logic                 consume;

    assign in_ready  = (state_q != Full);
    assign out_valid = (state_q != Empty);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        occupancy = '0;
        case (state_q)
            Busy:    occupancy = OccupancyWidth'(1);
            Full:    occupancy = OccupancyWidth'(2);
            default: occupancy = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= Empty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        payload_clear  = 1'b0;
        if (flush) begin
            // Squash drops any offered payload and every held entry.
            state_d       = Empty;
            payload_clear = ClearOnFlush;
        end else begin
            case (state_q)
                Empty: begin
                    if (accept) begin
                        state_d   = Busy;
                        main_load = 1'b1;
                    end
                end
                Busy: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_d   = Full;
                        skid_load = 1'b1;
                    end else if (consume) begin
                        state_d = Empty;
                    end
                end
                Full: begin
                    if (consume) begin
                        state_d        = Busy;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = Empty;
                end
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    pipeline_data_reg #(
        .DataWidth  (DataWidth),
        .ResetValue (ResetValue)
    ) u_main_reg (
        .clock (clock),
        .reset (reset),
        .load  (main_load),
        .clear (payload_clear),
        .d     (main_d),
        .q     (main_q)
    );

    pipeline_data_reg #(
        .DataWidth  (DataWidth),
        .ResetValue (ResetValue)
    ) u_skid_reg (
        .clock (clock),
        .reset (reset),
        .load  (skid_load),
        .clear (payload_clear),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// Scoreboard bench for pipeline_skid_reg: accepted payloads are queued,
// a negedge monitor pops and compares every downstream transfer.
module tb_pipeline_skid_reg;
    import pipeline_reg_pkg::*;

    localparam int W = 64;
    localparam logic [W-1:0] NcReset = 64'hDEAD;

    logic         clock = 1'b0;
    logic         reset;
    logic         flush, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    logic         nc_flush, nc_in_valid, nc_out_ready;
    logic [W-1:0] nc_in_data;
    logic         nc_in_ready, nc_out_valid;
    logic [W-1:0] nc_out_data;
    logic [1:0]   nc_occupancy;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    always #5 clock = ~clock;

    pipeline_skid_reg #(.DataWidth(W), .ResetValue('0), .ClearOnFlush(1'b1)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipeline_skid_reg #(.DataWidth(W), .ResetValue(NcReset), .ClearOnFlush(1'b0)) dut_nc (
        .clock(clock), .reset(reset), .flush(nc_flush),
        .in_valid(nc_in_valid), .in_ready(nc_in_ready), .in_data(nc_in_data),
        .out_valid(nc_out_valid), .out_ready(nc_out_ready), .out_data(nc_out_data),
        .occupancy(nc_occupancy)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every transfer downstream must match the oldest queued payload.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (!(dut.state_q inside {Empty, Busy, Full})) begin
                total++; bad++;
                $display("FAIL state_encoding: got %0d expected Empty/Busy/Full", dut.state_q);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_underflow: got %0h expected no transfer", out_data);
                end else begin
                    check("sb_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    // Upstream stability: a stalled offer must be held unless squashed.
    logic         p_v, p_r, p_f, p_rst;
    logic [W-1:0] p_d;
    initial begin p_v = 0; p_r = 1; p_f = 0; p_rst = 0; p_d = '0; end
    always @(posedge clock) begin
        if (p_v && !p_r && !p_f && p_rst && reset) begin
            if (!(in_valid && in_data == p_d)) begin
                total++; bad++;
                $display("FAIL in_hold: got v=%0b d=%0h expected v=1 d=%0h", in_valid, in_data, p_d);
            end
        end
        p_v = in_valid; p_r = in_ready; p_f = flush; p_rst = reset; p_d = in_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; flush = 0; in_valid = 1; in_data = 64'hA5; out_ready = 0;
        nc_flush = 0; nc_in_valid = 0; nc_in_data = '0; nc_out_ready = 0;
        step(); step();
        check("rst_out_valid", W'(out_valid), 0);
        check("rst_in_ready", W'(in_ready), 1);
        check("rst_occupancy", W'(occupancy), 0);
        check("rst_out_data", out_data, 0);
        check("rst_nc_out_data", nc_out_data, NcReset);
        reset = 1; in_valid = 0;
        step();

        // Streaming at full throughput
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1; in_data = W'(i);
            check("stream_in_ready", W'(in_ready), 1);
            step();
            exp_q.push_back(W'(i));
            check("stream_latency", out_data, W'(i));
        end
        in_valid = 0;
        step();
        check("stream_drain_occ", W'(occupancy), 0);

        // Fill skid buffer, then drain
        out_ready = 0;
        in_valid = 1; in_data = 64'h10; step(); exp_q.push_back(64'h10);
        in_data = 64'h11; step(); exp_q.push_back(64'h11);
        in_valid = 0;
        check("full_occ", W'(occupancy), 2);
        check("full_in_ready", W'(in_ready), 0);
        check("full_out_data", out_data, 64'h10);
        step();
        check("full_retention", out_data, 64'h10);
        out_ready = 1;
        step();
        check("drain1_occ", W'(occupancy), 1);
        check("drain1_data", out_data, 64'h11);
        step();
        check("drain2_occ", W'(occupancy), 0);
        out_ready = 0;

        // Flush while Full with an offered payload
        in_valid = 1; in_data = 64'h20; step(); exp_q.push_back(64'h20);
        in_data = 64'h21; step(); exp_q.push_back(64'h21);
        flush = 1; in_data = 64'h22;
        step();
        exp_q.delete();
        flush = 0; in_valid = 0;
        check("flush_occ", W'(occupancy), 0);
        check("flush_out_valid", W'(out_valid), 0);
        check("flush_clear_data", out_data, 0);
        out_ready = 1;
        step(); step();
        out_ready = 0;

        // Flush in Busy with a consume and an offer in the same cycle
        in_valid = 1; in_data = 64'h50; step(); exp_q.push_back(64'h50);
        out_ready = 1; flush = 1; in_data = 64'h51;
        step();
        exp_q.delete();
        flush = 0; in_valid = 0; out_ready = 0;
        check("flush_busy_occ", W'(occupancy), 0);
        check("flush_busy_in_ready", W'(in_ready), 1);

        // Back-to-back accept and consume in Busy
        in_valid = 1; in_data = 64'h30; step(); exp_q.push_back(64'h30);
        out_ready = 1; in_data = 64'h31;
        step(); exp_q.push_back(64'h31);
        in_valid = 0;
        check("b2b_occ", W'(occupancy), 1);
        check("b2b_data", out_data, 64'h31);
        step();
        check("b2b_drain_occ", W'(occupancy), 0);
        out_ready = 0;

        // Flush without payload clearing
        nc_in_valid = 1; nc_in_data = 64'h40; step();
        nc_in_valid = 0;
        check("nc_busy_occ", W'(nc_occupancy), 1);
        check("nc_busy_data", nc_out_data, 64'h40);
        nc_flush = 1; step(); nc_flush = 0;
        check("nc_flush_valid", W'(nc_out_valid), 0);
        check("nc_flush_data", nc_out_data, 64'h40);
        nc_in_valid = 1; nc_in_data = 64'h41; step(); nc_in_valid = 0;
        check("nc_reload_valid", W'(nc_out_valid), 1);
        check("nc_reload_data", nc_out_data, 64'h41);

        // Reset mid-transfer overrides flush and handshakes
        in_valid = 1; in_data = 64'h60; step(); exp_q.push_back(64'h60);
        in_data = 64'h61; step(); exp_q.push_back(64'h61);
        reset = 0; flush = 1; in_data = 64'h62; out_ready = 1;
        step();
        exp_q.delete();
        reset = 1; flush = 0; in_valid = 0; out_ready = 0;
        check("midrst_occ", W'(occupancy), 0);
        check("midrst_in_ready", W'(in_ready), 1);
        check("midrst_data", out_data, 0);
        step();

        check("sb_empty", W'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
